regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, 2-read file used by the RV64IF datapath.
- One instance serves as the integer file (ZERO_REG=1) and one as the FP file (ZERO_REG=0). The FP file needs 3 read ports for fused multiply-add.
- Adds two write ports, a per-register pending-write scoreboard and a sequential post-reset clear engine.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 3, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 hardwired to zero (integer file); 0 = entry 0 is an ordinary register (FP file).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_busy  out  NUM_RD  scoreboard bit for each rd_addr.
- wr0_en, wr0_addr, wr0_data  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 0 (ALU/FPU writeback).
- wr1_en, wr1_addr, wr1_data  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1 (load writeback).
- issue_en, issue_addr  in  1 / ADDR_WIDTH  marks issue_addr as pending a write.
- ready  out  1  high once the clear sequence completes.

Behaviour:
- Clear-engine state machine: states CLEAR and RUN, plus a clear counter clr_cnt of ADDR_WIDTH bits.
- Rst high at an edge: state<=CLEAR, clr_cnt<=0, ready<=0. This applies from any state, including mid-clear or mid-operation (the clear restarts from entry 0).
- CLEAR, Rst low: each edge writes 0 to entry clr_cnt, clears busy[clr_cnt] and increments clr_cnt.
- CLEAR to RUN: the edge that clears entry DEPTH-1 sets state<=RUN and ready<=1. This is the DEPTH-th edge with Rst low (32 edges at default).
- During CLEAR: wr0_en, wr1_en and issue_en are ignored; rd_data=0; rd_busy=0.
- Output reset values: ready=0, rd_data=0, rd_busy=0.
- Reads: combinational from the array; zero-cycle latency.
  - ZERO_REG=1 and rd_addr==0: rd_data=0 and rd_busy=0.
- Writes (RUN only): committed at posedge.
  - Both write enables high with different addresses: both entries written.
  - Both high with the same address: wr1_data wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Scoreboard (RUN only), per entry, evaluated at posedge:
  - busy clears on a write (wr0 or wr1) to that address.
  - busy sets on issue_en to that address.
  - Set and clear of the same address in one cycle: set wins (the new issue is younger).
  - ZERO_REG=1: issue to address 0 is ignored.
- rd_busy[i] = busy[rd_addr_i], subject to the bypass rule below.
- No arithmetic; address comparisons are full ADDR_WIDTH equality.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding in RUN.
  - If wrX_en is high and wrX_addr==rd_addr_i (and the address is not a hardwired zero), rd_data_i = wrX_data in the same cycle; wr1 has priority over wr0.
  - rd_busy_i = 0 when a write to rd_addr_i occurs in the same cycle, unless issue_en targets that address in the same cycle.
- Undefined: reads return the pre-edge array value; rd_busy reflects registered busy only.
- The clear engine is identical in both builds.

Decomposition:
- Shared package/header holds:
  - clear-engine state encodings: ST_CLEAR=1'b0, ST_RUN=1'b1;
  - the DEPTH derivation;
  - default width constants shared with the decode stage (XLEN=64, REG_ADDR_W=5).
- Sub-module regfile_read_port: one read lane (array mux, zero-register masking, CLEAR masking, optional bypass mux, busy select). Instantiated NUM_RD times via generate.
- The array, scoreboard and clear engine stay in the top.

Test Plan:
- Reset/clear: preload via writes, pulse Rst 1 cycle, then hold Rst low -> ready=0 for 31 edges and 1 after the 32nd; all reads of 0..31 return 0.
- Dual write: RUN, wr0 (addr 5, 0xAAAA), wr1 (addr 5, 0x5555) same cycle -> next cycle rd_addr0=5 returns 0x5555. wr0 (3, 0x11) with wr1 (4, 0x22) -> both stored.
- Zero register:
  - ZERO_REG=1: write 0xDEAD to addr 0 and issue addr 0 -> rd_data=0, rd_busy=0.
  - ZERO_REG=0: same write -> reads 0xDEAD.
- Scoreboard: issue addr 7 -> rd_busy=1 next cycle. wr0 to 7 with issue 7 in the same cycle -> busy stays 1. A later lone wr1 to 7 -> busy=0.
- Reset mid-operation: Rst pulsed while clr_cnt=12 -> counter restarts; ready rises exactly 32 Rst-low edges after the pulse.
- Bypass: wr0 (9, 0x1234) with rd_addr1=9 same cycle -> REGFILE_BYPASS_EN defined: rd_data1=0x1234 that cycle; undefined: old value that cycle, 0x1234 the next.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file and the decode stage.
// No logic; widths, clear-engine state encodings and the depth derivation.
// Imported by regfile_mp and regfile_read_port.
package regfile_mp_pkg;

    // Default widths shared with the decode stage
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Clear-engine states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

    // Number of entries addressed by an address of the given width
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane: array mux, zero-register and clear masking, busy select.
// Latency: zero cycles. No backpressure; the lane follows its address every cycle.
// Build option REGFILE_BYPASS_EN adds same-cycle write-through forwarding (wr1 over wr0).
module regfile_read_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DEPTH      = depth_of(ADDR_WIDTH),
    parameter int ZERO_REG   = 1
) (
    input  logic                        run,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
    input  logic [DEPTH-1:0]            busy,
    // Write/issue strobes arrive already qualified (RUN, not reset, not a dropped zero-address write)
    input  logic                        wr0_en,
    input  logic [ADDR_WIDTH-1:0]       wr0_addr,
    input  logic [DATA_WIDTH-1:0]       wr0_data,
    input  logic                        wr1_en,
    input  logic [ADDR_WIDTH-1:0]       wr1_addr,
    input  logic [DATA_WIDTH-1:0]       wr1_data,
    input  logic                        issue_en,
    input  logic [ADDR_WIDTH-1:0]       issue_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_busy
);

    logic zero_hit;
    assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

`ifdef REGFILE_BYPASS_EN
    logic wr0_hit, wr1_hit, issue_hit;
    assign wr0_hit   = wr0_en   && (wr0_addr   == rd_addr);
    assign wr1_hit   = wr1_en   && (wr1_addr   == rd_addr);
    assign issue_hit = issue_en && (issue_addr == rd_addr);
`else
    // Forwarding inputs only matter in the bypass build
    logic unused_fwd;
    assign unused_fwd = ^{wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
                          issue_en, issue_addr};
`endif

    // Select array entry and busy bit, masked during clear and for the hardwired zero
    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (run && !zero_hit) begin
            rd_data = mem_flat[rd_addr*DATA_WIDTH +: DATA_WIDTH];
            rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr0_hit) begin
                rd_data = wr0_data;
            end
            if (wr1_hit) begin
                rd_data = wr1_data;
            end
            // A same-cycle write retires the pending entry unless a younger issue re-arms it
            if ((wr0_hit || wr1_hit) && !issue_hit) begin
                rd_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read lanes, two write ports, pending-write scoreboard, clear engine.
// Latency: reads combinational, writes/scoreboard commit at posedge; ready rises DEPTH edges after reset.
// No backpressure; writes and issues are ignored while clearing. Option macro: REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_RD     = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr0_en,
    input  logic [ADDR_WIDTH-1:0]        wr0_addr,
    input  logic [DATA_WIDTH-1:0]        wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_WIDTH-1:0]        wr1_addr,
    input  logic [DATA_WIDTH-1:0]        wr1_data,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic                         ready
);

    localparam int                    DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    clr_state_t                            state, state_nxt;
    logic [ADDR_WIDTH-1:0]                 clr_cnt, clr_cnt_nxt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]      mem;
    logic [DEPTH-1:0]                      busy, busy_nxt;

    logic run, clr_step, run_step;
    logic wr0_ok, wr1_ok, issue_ok;

    assign run      = (state == ST_RUN);
    assign ready    = run;
    assign clr_step = (state == ST_CLEAR) && !Rst;
    assign run_step = run && !Rst;

    // Address 0 is not a real storage location in the integer file
    assign wr0_ok   = run_step && wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
    assign wr1_ok   = run_step && wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
    assign issue_ok = run_step && issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    // Clear-engine state register; reset restarts the sweep from entry 0 from any state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear-engine next state: one entry per edge, RUN on the edge that clears the last entry
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + CNT_ONE;
                if (clr_cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Array update: clear sweep, or both write ports with wr1 landing last on an address clash
    always_ff @(posedge Clk) begin
        if (clr_step) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem[wr1_addr] <= wr1_data;
            end
        end
    end

    // Scoreboard next value: writes retire entries, issue marks them; issue applied last so it wins
    always_comb begin
        busy_nxt = busy;
        if (clr_step) begin
            busy_nxt[clr_cnt] = 1'b0;
        end else begin
            if (wr0_ok) begin
                busy_nxt[wr0_addr] = 1'b0;
            end
            if (wr1_ok) begin
                busy_nxt[wr1_addr] = 1'b0;
            end
            if (issue_ok) begin
                busy_nxt[issue_addr] = 1'b1;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge Clk) begin
        busy <= busy_nxt;
    end

    logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
    assign mem_flat = mem;

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            regfile_read_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .DEPTH      (DEPTH),
                .ZERO_REG   (ZERO_REG)
            ) u_rd (
                .run        (run),
                .rd_addr    (rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
                .mem_flat   (mem_flat),
                .busy       (busy),
                .wr0_en     (wr0_ok),
                .wr0_addr   (wr0_addr),
                .wr0_data   (wr0_data),
                .wr1_en     (wr1_ok),
                .wr1_addr   (wr1_addr),
                .wr1_data   (wr1_data),
                .issue_en   (issue_ok),
                .issue_addr (issue_addr),
                .rd_data    (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .rd_busy    (rd_busy[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: integer-file instance (ZERO_REG=1) and FP-file instance (ZERO_REG=0).
// Expected read values are queued when stimulus is driven and popped when the outputs are sampled.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 3;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [NR*AW-1:0]  rd_addr;
    logic              wr0_en, wr1_en, issue_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, issue_addr;
    logic [DW-1:0]     wr0_data, wr1_data;

    logic [NR*DW-1:0]  int_rd_data, fp_rd_data;
    logic [NR-1:0]     int_rd_busy, fp_rd_busy;
    logic              int_ready, fp_ready;

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) u_int (
        .Clk(Clk), .Rst(Rst), .rd_addr(rd_addr), .rd_data(int_rd_data), .rd_busy(int_rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(int_ready)
    );

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(0)) u_fp (
        .Clk(Clk), .Rst(Rst), .rd_addr(rd_addr), .rd_data(fp_rd_data), .rd_busy(fp_rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(fp_ready)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic exp_pop(input string tag, input logic [DW-1:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=%h exp=<scoreboard empty>", tag, got);
        end else begin
            chk(tag, got, exp_q.pop_front());
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [NR*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
    endtask

    // One reset pulse, then count Rst-low edges until ready must rise
    task automatic reset_and_clear(input string tag);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk({tag, "_ready_rst"}, {63'd0, int_ready}, 64'd0);
        for (int n = 1; n <= 32; n++) begin
            step();
            chk({tag, "_ready"}, {63'd0, int_ready}, (n == 32) ? 64'd1 : 64'd0);
        end
        chk({tag, "_fp_ready"}, {63'd0, fp_ready}, 64'd1);
    endtask

    initial begin
        Rst = 1'b0;
        rd_addr = '0;
        wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
        wr0_data = '0; wr1_data = '0;
        idle();
        step();

        // Initial clear
        reset_and_clear("init");

        // Preload every entry, confirm one, mark a few busy
        for (int a = 1; a < 32; a++) begin
            wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = 64'hC0DE_0000_0000_0000 | 64'(a);
            issue_en = (a < 4); issue_addr = AW'(a + 10);
            step();
        end
        idle();
        set_rd(0, 5'd17);
        exp_push(64'hC0DE_0000_0000_0011);
        #1;
        exp_pop("preload_rd", lane(int_rd_data, 0));

        // Clear after preload: every entry reads back zero and not busy
        reset_and_clear("clr");
        for (int a = 0; a < 32; a++) begin
            set_rd(2, AW'(a));
            exp_push(64'd0);
            exp_push(64'd0);
            #1;
            exp_pop("clr_rd", lane(int_rd_data, 2));
            exp_pop("clr_busy", {63'd0, int_rd_busy[2]});
        end

        // Dual write, same address: wr1 wins
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 64'h5555;
        step();
        idle();
        set_rd(0, 5'd5);
        exp_push(64'h5555);
        #1;
        exp_pop("dual_same", lane(int_rd_data, 0));

        // Dual write, different addresses: both stored
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h11;
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 64'h22;
        step();
        idle();
        set_rd(0, 5'd3); set_rd(1, 5'd4);
        exp_push(64'h11); exp_push(64'h22);
        #1;
        exp_pop("dual_diff0", lane(int_rd_data, 0));
        exp_pop("dual_diff1", lane(int_rd_data, 1));

        // Zero register: write + issue address 0
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hDEAD;
        issue_en = 1'b1; issue_addr = 5'd0;
        step();
        idle();
        set_rd(0, 5'd0);
        exp_push(64'd0); exp_push(64'd0); exp_push(64'hDEAD); exp_push(64'd1);
        #1;
        exp_pop("zero_int_data", lane(int_rd_data, 0));
        exp_pop("zero_int_busy", {63'd0, int_rd_busy[0]});
        exp_pop("zero_fp_data",  lane(fp_rd_data, 0));
        exp_pop("zero_fp_busy",  {63'd0, fp_rd_busy[0]});

        // Scoreboard: issue sets busy
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        idle();
        set_rd(0, 5'd7);
        exp_push(64'd1);
        #1;
        exp_pop("sb_issue", {63'd0, int_rd_busy[0]});

        // Write and issue to the same entry: busy stays set, data updated
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h77;
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        idle();
        exp_push(64'd1); exp_push(64'h77);
        #1;
        exp_pop("sb_set_wins", {63'd0, int_rd_busy[0]});
        exp_pop("sb_set_data", lane(int_rd_data, 0));

        // Lone wr1 retires the entry
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h78;
        step();
        idle();
        exp_push(64'd0); exp_push(64'h78);
        #1;
        exp_pop("sb_clear", {63'd0, int_rd_busy[0]});
        exp_pop("sb_clear_data", lane(int_rd_data, 0));

        // Writes during clear are ignored
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        wr0_en = 1'b1; wr0_addr = 5'd31; wr0_data = 64'hBAD;
        issue_en = 1'b1; issue_addr = 5'd31;
        repeat (3) step();
        idle();
        set_rd(1, 5'd31);
        exp_push(64'd0);
        #1;
        exp_pop("clr_rd_masked", lane(int_rd_data, 1));

        // Mid-clear reset at clr_cnt=12 restarts the sweep (3 edges already done above)
        repeat (9) step();
        reset_and_clear("mid");
        exp_push(64'd0); exp_push(64'd0);
        #1;
        exp_pop("mid_wr_dropped", lane(int_rd_data, 1));
        exp_pop("mid_busy_dropped", {63'd0, int_rd_busy[1]});

        // Bypass: write 9 while reading it on lane 1
        set_rd(1, 5'd9);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h1234;
`ifdef REGFILE_BYPASS_EN
        exp_push(64'h1234);
`else
        exp_push(64'd0);
`endif
        #1;
        exp_pop("byp_same_cycle", lane(int_rd_data, 1));
        step();
        idle();
        exp_push(64'h1234);
        #1;
        exp_pop("byp_next_cycle", lane(int_rd_data, 1));

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
